governance_sequencer: RTL and testbench
=======================================

GOVERNANCE_SEQUENCER -- requirements
Module: governance_sequencer

Interface
REQ-001 SHALL have parameter N_REQ, default 3: number of approval requesters (0=FRAM, 1=serial, 2=TSSP).
REQ-002 SHALL have parameter HASH_BITS, default 128: approval hash width.
REQ-003 SHALL have parameter RSP_TIMEOUT, default 1024: maximum cycles to wait for a per-approval ack or reject.
REQ-004 clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 deploy_req  in  1  level; requests a governance session.
REQ-006 req_valid  in  N_REQ  approval pending, one bit per requester; req_signer_id  in  8*N_REQ; req_hash  in  HASH_BITS*N_REQ.
REQ-007 req_grant  out  N_REQ  one-hot pulse; the requester's approval is consumed.
REQ-008 rsp_valid  out  N_REQ  one-hot pulse; rsp_accepted  out  1  is valid with rsp_valid.
REQ-009 gov_check_start  out  1; gov_approval_valid  out  1; gov_signer_id  out  8; gov_hash  out  HASH_BITS.
REQ-010 gov_approval_ack, gov_approval_reject, gov_check_done, gov_approved, gov_denied, gov_timeout  in  1 each; these come from the threshold checker.
REQ-011 session_done  out  1  pulse; session_approved  out  1; session_denied  out  1; session_timeout  out  1; busy  out  1; state  out  3.

Function
REQ-012 FSM states SHALL be IDLE, ARB, ISSUE, WAIT, CLOSE and DRAIN.
REQ-013 IDLE: when deploy_req=1, the block SHALL assert gov_check_start and busy and go to ARB.
REQ-014 gov_check_start SHALL stay high from ARB through WAIT.
REQ-015 In CLOSE and DRAIN, gov_check_start SHALL be low.
REQ-016 ARB: if gov_check_done=1, the block SHALL go to CLOSE; otherwise, if any req_valid=1, it SHALL select one requester, pulse its req_grant, latch its id and hash, and go to ISSUE.
REQ-017 ISSUE: the block SHALL drive gov_approval_valid=1 for exactly 1 cycle with the latched id and hash, then go to WAIT.
REQ-018 WAIT, gov_approval_ack: the block SHALL pulse rsp_valid[sel] with rsp_accepted=1 and return to ARB.
REQ-019 WAIT, gov_approval_reject: the block SHALL pulse rsp_valid[sel] with rsp_accepted=0 and return to ARB.
REQ-020 WAIT, gov_check_done=1 before ack or reject: the block SHALL pulse rsp_valid[sel] with rsp_accepted=0 and go to CLOSE.
REQ-021 WAIT, RSP_TIMEOUT cycles elapse with no ack or reject: the block SHALL pulse rsp_valid[sel] with rsp_accepted=0 and return to ARB.
REQ-022 ack and reject asserted in the same cycle SHALL be treated as reject.
REQ-023 CLOSE: the block SHALL latch gov_approved, gov_denied and gov_timeout into the session_* outputs, pulse session_done for 1 cycle, and go to DRAIN.
REQ-024 DRAIN: the block SHALL wait for gov_check_done=0, then go to IDLE and clear busy.
REQ-025 session_* outputs SHALL hold their values until the next session starts.
REQ-026 Arbitration latency SHALL be 1 cycle from ARB to grant.
REQ-027 Each requester SHALL receive at most one grant per arbitration round.
REQ-028 The timeout counter SHALL be 16 bits, SHALL clear on entry to WAIT, and SHALL saturate (never wrap).
REQ-029 deploy_req=0 mid-session SHALL be ignored; a session always completes.
REQ-030 A deploy_req that remains high in IDLE after DRAIN SHALL start a new session.

Reset
REQ-031 Reset SHALL put the FSM in IDLE and drive all outputs to 0, including gov_check_start, grants, responses and session_*.
REQ-032 Reset SHALL set the round-robin pointer to 0 and the timeout counter to 0.
REQ-033 Reset asserted mid-session SHALL abort the session with no rsp_valid and no session_done.

Configuration
REQ-034 With GOV_SEQ_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority, with the lowest index (FRAM preload) first.
REQ-035 Without GOV_SEQ_FIXED_PRIO_EN, arbitration SHALL be round-robin, starting after the last granted index.

Structure
REQ-036 A shared package gov_pkg SHALL hold the FSM state encoding, the requester index constants (REQ_FRAM, REQ_SERIAL, REQ_TSSP) and the default HASH_BITS.
REQ-037 The arbiter SHALL be a separate sub-module, gov_rr_arbiter, containing the req/grant logic, the pointer and the GOV_SEQ_FIXED_PRIO_EN switch.

Verification
REQ-038 Scenario: deploy_req with five distinct signers queued on requester 1, checker acks each -> 5 grants and 5 rsp_accepted=1; checker gov_check_done+gov_approved -> session_done pulse with session_approved=1.
REQ-039 Scenario: requesters 0, 1 and 2 all valid continuously, round-robin build -> grant order 0,1,2,0,1,2; fixed-priority build -> grant order 0,0,0 while req_valid[0] is held.
REQ-040 Scenario: duplicate signer 3, checker rejects -> rsp_accepted=0 to that requester, and the session continues.
REQ-041 Scenario: checker silent for 1024 cycles after ISSUE -> rsp_valid with rsp_accepted=0, and the FSM returns to ARB.
REQ-042 Scenario: gov_timeout+gov_denied+gov_check_done during WAIT -> rsp_accepted=0, session_timeout=1, gov_check_start low until gov_check_done falls.
REQ-043 Scenario: rst_n low in WAIT -> all outputs 0 next cycle, state=IDLE, no session_done.

Source files
------------

// File: rtl/governance_sequencer_pkg.sv
// Shared definitions for the governance sequencer: FSM state encoding,
// requester index constants, default sizing and a saturating counter helper.
package gov_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CLOSE = 3'd4,
        ST_DRAIN = 3'd5
    } gov_state_e;

    localparam int REQ_FRAM        = 0;
    localparam int REQ_SERIAL      = 1;
    localparam int REQ_TSSP        = 2;

    localparam int GOV_N_REQ       = 3;
    localparam int GOV_HASH_BITS   = 128;
    localparam int GOV_RSP_TIMEOUT = 1024;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/governance_sequencer_if.sv
// Requester and threshold-checker signal bundle for the governance sequencer.
// master = sequencer side, slave = requesters/checker side.
interface governance_sequencer_if
    import gov_pkg::*;
#(
    parameter int N_REQ     = GOV_N_REQ,
    parameter int HASH_BITS = GOV_HASH_BITS
);
    logic [N_REQ-1:0]           req_valid;
    logic [8*N_REQ-1:0]         req_signer_id;
    logic [HASH_BITS*N_REQ-1:0] req_hash;
    logic [N_REQ-1:0]           req_grant;
    logic [N_REQ-1:0]           rsp_valid;
    logic                       rsp_accepted;

    logic                       gov_check_start;
    logic                       gov_approval_valid;
    logic [7:0]                 gov_signer_id;
    logic [HASH_BITS-1:0]       gov_hash;
    logic                       gov_approval_ack;
    logic                       gov_approval_reject;
    logic                       gov_check_done;
    logic                       gov_approved;
    logic                       gov_denied;
    logic                       gov_timeout;

    modport master (
        input  req_valid, req_signer_id, req_hash,
        input  gov_approval_ack, gov_approval_reject, gov_check_done,
        input  gov_approved, gov_denied, gov_timeout,
        output req_grant, rsp_valid, rsp_accepted,
        output gov_check_start, gov_approval_valid, gov_signer_id, gov_hash
    );

    modport slave (
        output req_valid, req_signer_id, req_hash,
        output gov_approval_ack, gov_approval_reject, gov_check_done,
        output gov_approved, gov_denied, gov_timeout,
        input  req_grant, rsp_valid, rsp_accepted,
        input  gov_check_start, gov_approval_valid, gov_signer_id, gov_hash
    );
endinterface

// File: rtl/gov_rr_arbiter.sv
// Requester arbiter. Round-robin from a next-first pointer by default;
// GOV_SEQ_FIXED_PRIO_EN selects fixed priority with index 0 highest.
module gov_rr_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic             advance_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             any_o
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] start_s;
    logic [PTR_W-1:0] gidx_s;
    logic [N_REQ-1:0] req_rot_s;
    logic [N_REQ-1:0] gnt_rot_s;
    logic [2*N_REQ-1:0] gnt_dbl_s;

`ifdef GOV_SEQ_FIXED_PRIO_EN
    assign start_s = '0;
`else
    assign start_s = ptr_q;
`endif

    // Rotate so the search origin sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_rot_s = N_REQ'({req_i, req_i} >> start_s);
        gnt_rot_s = req_rot_s & (~req_rot_s + N_REQ'(1));
        gnt_dbl_s = {{N_REQ{1'b0}}, gnt_rot_s} << start_s;
        grant_o   = gnt_dbl_s[N_REQ-1:0] | gnt_dbl_s[2*N_REQ-1:N_REQ];
        any_o     = |req_i;
    end

    // Pointer moves to the index just after the one granted this cycle.
    always_comb begin
        gidx_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gidx_s = gidx_s | (grant_o[i] ? PTR_W'(i) : '0);
        end
        if (advance_i) begin
            ptr_d = (gidx_s == PTR_W'(N_REQ - 1)) ? '0 : (gidx_s + PTR_W'(1));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/governance_sequencer.sv
// Governance session sequencer: arbitrates approval requesters, feeds them one
// at a time to the threshold checker and reports the session outcome.
// Optional build macro: GOV_SEQ_FIXED_PRIO_EN (fixed-priority arbitration).
module governance_sequencer
    import gov_pkg::*;
#(
    parameter int N_REQ       = GOV_N_REQ,
    parameter int HASH_BITS   = GOV_HASH_BITS,
    parameter int RSP_TIMEOUT = GOV_RSP_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   deploy_req,
    governance_sequencer_if.master bus,
    output logic                   session_done,
    output logic                   session_approved,
    output logic                   session_denied,
    output logic                   session_timeout,
    output logic                   busy,
    output logic [2:0]             state
);
    localparam logic [15:0] TMO_LAST = 16'(RSP_TIMEOUT - 1);

    gov_state_e           state_q, state_d;
    logic [N_REQ-1:0]     sel_q, sel_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [N_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic                 rsp_acc_q, rsp_acc_d;
    logic                 start_q, start_d;
    logic                 appr_valid_q, appr_valid_d;
    logic [7:0]           id_q, id_d;
    logic [HASH_BITS-1:0] hash_q, hash_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 sess_done_q, sess_done_d;
    logic                 sess_appr_q, sess_appr_d;
    logic                 sess_den_q, sess_den_d;
    logic                 sess_tmo_q, sess_tmo_d;
    logic                 busy_q, busy_d;

    logic [N_REQ-1:0]     arb_grant_s;
    logic                 arb_any_s;
    logic                 arb_take_s;
    logic [7:0]           pick_id_s;
    logic [HASH_BITS-1:0] pick_hash_s;

    assign arb_take_s = (state_q == ST_ARB) & ~bus.gov_check_done & arb_any_s;

    gov_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (bus.req_valid),
        .advance_i (arb_take_s),
        .grant_o   (arb_grant_s),
        .any_o     (arb_any_s)
    );

    // One-hot select of the granted requester's signer id and hash.
    always_comb begin
        pick_id_s   = 8'h00;
        pick_hash_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pick_id_s   = pick_id_s | ({8{arb_grant_s[i]}} & bus.req_signer_id[8*i +: 8]);
            pick_hash_s = pick_hash_s |
                          ({HASH_BITS{arb_grant_s[i]}} & bus.req_hash[HASH_BITS*i +: HASH_BITS]);
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        id_d        = id_q;
        hash_d      = hash_q;
        cnt_d       = cnt_q;
        grant_d     = '0;
        rsp_valid_d = '0;
        rsp_acc_d   = 1'b0;
        sess_done_d = 1'b0;
        sess_appr_d = sess_appr_q;
        sess_den_d  = sess_den_q;
        sess_tmo_d  = sess_tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (deploy_req) begin
                    state_d     = ST_ARB;
                    sess_appr_d = 1'b0;
                    sess_den_d  = 1'b0;
                    sess_tmo_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (bus.gov_check_done) begin
                    state_d = ST_CLOSE;
                end else if (arb_any_s) begin
                    state_d = ST_ISSUE;
                    grant_d = arb_grant_s;
                    sel_d   = arb_grant_s;
                    id_d    = pick_id_s;
                    hash_d  = pick_hash_s;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = 16'd0;
            end
            ST_WAIT: begin
                cnt_d = sat_inc16(cnt_q);
                // Reject outranks ack so a simultaneous pair is a reject.
                if (bus.gov_approval_reject) begin
                    state_d     = ST_ARB;
                    rsp_valid_d = sel_q;
                end else if (bus.gov_approval_ack) begin
                    state_d     = ST_ARB;
                    rsp_valid_d = sel_q;
                    rsp_acc_d   = 1'b1;
                end else if (bus.gov_check_done) begin
                    state_d     = ST_CLOSE;
                    rsp_valid_d = sel_q;
                end else if (cnt_q >= TMO_LAST) begin
                    state_d     = ST_ARB;
                    rsp_valid_d = sel_q;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_CLOSE: begin
                state_d     = ST_DRAIN;
                sess_done_d = 1'b1;
                sess_appr_d = bus.gov_approved;
                sess_den_d  = bus.gov_denied;
                sess_tmo_d  = bus.gov_timeout;
            end
            ST_DRAIN: begin
                if (!bus.gov_check_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        start_d      = (state_d == ST_ARB) | (state_d == ST_ISSUE) | (state_d == ST_WAIT);
        busy_d       = (state_d != ST_IDLE);
        appr_valid_d = (state_d == ST_ISSUE);
    end

    // State and output registers; reset aborts any session silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            grant_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_acc_q    <= 1'b0;
            start_q      <= 1'b0;
            appr_valid_q <= 1'b0;
            id_q         <= 8'h00;
            hash_q       <= '0;
            cnt_q        <= 16'd0;
            sess_done_q  <= 1'b0;
            sess_appr_q  <= 1'b0;
            sess_den_q   <= 1'b0;
            sess_tmo_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            grant_q      <= grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_acc_q    <= rsp_acc_d;
            start_q      <= start_d;
            appr_valid_q <= appr_valid_d;
            id_q         <= id_d;
            hash_q       <= hash_d;
            cnt_q        <= cnt_d;
            sess_done_q  <= sess_done_d;
            sess_appr_q  <= sess_appr_d;
            sess_den_q   <= sess_den_d;
            sess_tmo_q   <= sess_tmo_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_grant          = grant_q;
    assign bus.rsp_valid          = rsp_valid_q;
    assign bus.rsp_accepted       = rsp_acc_q;
    assign bus.gov_check_start    = start_q;
    assign bus.gov_approval_valid = appr_valid_q;
    assign bus.gov_signer_id      = id_q;
    assign bus.gov_hash           = hash_q;
    assign session_done           = sess_done_q;
    assign session_approved       = sess_appr_q;
    assign session_denied         = sess_den_q;
    assign session_timeout        = sess_tmo_q;
    assign busy                   = busy_q;
    assign state                  = state_q;
endmodule

// File: tb/tb_governance_sequencer.sv
// Directed self-checking bench for governance_sequencer: signer queue with acks,
// arbitration order, rejects, response timeout, checker abort and mid-session reset.
module tb_governance_sequencer;
    import gov_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       deploy_req;
    logic       session_done, session_approved, session_denied, session_timeout, busy;
    logic [2:0] state;
    int         checks;
    int         errors;
    int         n_acc;
    int         n;
    logic [7:0] id;
    logic [2:0] exp_order [6];

    governance_sequencer_if #(.N_REQ(3), .HASH_BITS(128)) bus ();

    governance_sequencer #(.N_REQ(3), .HASH_BITS(128), .RSP_TIMEOUT(1024)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .deploy_req       (deploy_req),
        .bus              (bus),
        .session_done     (session_done),
        .session_approved (session_approved),
        .session_denied   (session_denied),
        .session_timeout  (session_timeout),
        .busy             (busy),
        .state            (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [7:0] sid);
        bus.req_signer_id[8*idx +: 8]   = sid;
        bus.req_hash[128*idx +: 128]    = {16{sid}};
    endtask

    task automatic wait_grant(input string tag, input logic [2:0] exp);
        int k;
        k = 0;
        do begin
            step(1);
            k++;
        end while (bus.req_grant == 3'b000 && k < 20);
        check(tag, bus.req_grant, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        deploy_req = 1'b0;
        bus.req_valid = 3'b000;
        bus.req_signer_id = '0;
        bus.req_hash = '0;
        bus.gov_approval_ack = 1'b0;
        bus.gov_approval_reject = 1'b0;
        bus.gov_check_done = 1'b0;
        bus.gov_approved = 1'b0;
        bus.gov_denied = 1'b0;
        bus.gov_timeout = 1'b0;

        step(2);
        check("rst_state", state, ST_IDLE);
        check("rst_busy", busy, 1'b0);
        check("rst_start", bus.gov_check_start, 1'b0);
        check("rst_grant", bus.req_grant, 3'b000);
        check("rst_rsp", bus.rsp_valid, 3'b000);
        check("rst_sdone", session_done, 1'b0);
        check("rst_appr", bus.gov_approval_valid, 1'b0);
        rst_n = 1'b1;

        // Five signers queued on the serial requester, each acked.
        deploy_req = 1'b1;
        set_req(REQ_SERIAL, 8'h11);
        bus.req_valid = 3'b010;
        step(1);
        check("A_state_arb", state, ST_ARB);
        check("A_start", bus.gov_check_start, 1'b1);
        check("A_busy", busy, 1'b1);
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            id = 8'h11 + 8'(k);
            wait_grant("A_grant", 3'b010);
            check("A_issue_valid", bus.gov_approval_valid, 1'b1);
            check("A_issue_id", bus.gov_signer_id, id);
            check("A_issue_hash", bus.gov_hash, {16{id}});
            if (k < 4) set_req(REQ_SERIAL, id + 8'h01);
            else bus.req_valid = 3'b000;
            step(1);
            check("A_issue_once", bus.gov_approval_valid, 1'b0);
            check("A_state_wait", state, ST_WAIT);
            bus.gov_approval_ack = 1'b1;
            step(1);
            bus.gov_approval_ack = 1'b0;
            check("A_rsp", bus.rsp_valid, 3'b010);
            if (bus.rsp_valid == 3'b010 && bus.rsp_accepted) n_acc++;
        end
        check("A_accept_count", n_acc, 5);
        bus.gov_check_done = 1'b1;
        bus.gov_approved = 1'b1;
        step(1);
        check("A_close", state, ST_CLOSE);
        check("A_close_start", bus.gov_check_start, 1'b0);
        step(1);
        check("A_sdone", session_done, 1'b1);
        check("A_sappr", session_approved, 1'b1);
        check("A_drain", state, ST_DRAIN);
        bus.gov_check_done = 1'b0;
        bus.gov_approved = 1'b0;
        deploy_req = 1'b0;
        step(1);
        check("A_sdone_pulse", session_done, 1'b0);
        check("A_idle_busy", busy, 1'b0);
        check("A_sappr_hold", session_approved, 1'b1);

        // Reset so the arbitration pointer starts from index 0.
        rst_n = 1'b0;
        step(1);
        check("B_rst_sappr", session_approved, 1'b0);
        rst_n = 1'b1;
`ifdef GOV_SEQ_FIXED_PRIO_EN
        exp_order = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
        set_req(REQ_FRAM, 8'hA0);
        set_req(REQ_SERIAL, 8'hA1);
        set_req(REQ_TSSP, 8'hA2);
        bus.req_valid = 3'b111;
        deploy_req = 1'b1;
        step(1);
        for (int k = 0; k < 6; k++) begin
            wait_grant("B_grant_order", exp_order[k]);
            step(1);
            bus.gov_approval_ack = 1'b1;
            step(1);
            bus.gov_approval_ack = 1'b0;
            check("B_rsp", bus.rsp_valid, exp_order[k]);
        end

        // Duplicate signer 3 rejected; session must keep going.
        set_req(REQ_TSSP, 8'h03);
        bus.req_valid = 3'b100;
        wait_grant("C_grant", 3'b100);
        check("C_id", bus.gov_signer_id, 8'h03);
        step(1);
        bus.gov_approval_reject = 1'b1;
        set_req(REQ_FRAM, 8'h03);
        bus.req_valid = 3'b001;
        step(1);
        bus.gov_approval_reject = 1'b0;
        check("C_rsp", bus.rsp_valid, 3'b100);
        check("C_rsp_acc", bus.rsp_accepted, 1'b0);
        check("C_continue", state, ST_ARB);
        check("C_start", bus.gov_check_start, 1'b1);
        wait_grant("C_grant2", 3'b001);
        bus.req_valid = 3'b000;
        step(1);
        bus.gov_approval_ack = 1'b1;
        bus.gov_approval_reject = 1'b1;
        step(1);
        bus.gov_approval_ack = 1'b0;
        bus.gov_approval_reject = 1'b0;
        check("C_both_rsp", bus.rsp_valid, 3'b001);
        check("C_both_acc", bus.rsp_accepted, 1'b0);

        // Silent checker: response after 1024 WAIT cycles.
        set_req(REQ_FRAM, 8'h44);
        bus.req_valid = 3'b001;
        wait_grant("D_grant", 3'b001);
        bus.req_valid = 3'b000;
        n = 0;
        do begin
            step(1);
            n++;
        end while (bus.rsp_valid == 3'b000 && n < 1100);
        check("D_latency", n, 1025);
        check("D_rsp", bus.rsp_valid, 3'b001);
        check("D_rsp_acc", bus.rsp_accepted, 1'b0);
        check("D_back_arb", state, ST_ARB);

        // Checker aborts with timeout+denied during WAIT.
        set_req(REQ_SERIAL, 8'h55);
        bus.req_valid = 3'b010;
        wait_grant("E_grant", 3'b010);
        bus.req_valid = 3'b000;
        step(1);
        bus.gov_timeout = 1'b1;
        bus.gov_denied = 1'b1;
        bus.gov_check_done = 1'b1;
        step(1);
        check("E_rsp", bus.rsp_valid, 3'b010);
        check("E_rsp_acc", bus.rsp_accepted, 1'b0);
        check("E_close", state, ST_CLOSE);
        check("E_start_low", bus.gov_check_start, 1'b0);
        step(1);
        check("E_sdone", session_done, 1'b1);
        check("E_stmo", session_timeout, 1'b1);
        check("E_sden", session_denied, 1'b1);
        check("E_sappr", session_approved, 1'b0);
        step(3);
        check("E_drain_hold", state, ST_DRAIN);
        check("E_drain_start", bus.gov_check_start, 1'b0);
        check("E_drain_busy", busy, 1'b1);
        bus.gov_check_done = 1'b0;
        bus.gov_timeout = 1'b0;
        bus.gov_denied = 1'b0;
        step(1);
        check("E_idle", state, ST_IDLE);
        check("E_stmo_hold", session_timeout, 1'b1);
        step(1);
        check("E_restart", state, ST_ARB);
        check("E_restart_start", bus.gov_check_start, 1'b1);
        check("E_stmo_clear", session_timeout, 1'b0);

        // Reset while waiting on the checker.
        set_req(REQ_FRAM, 8'h77);
        bus.req_valid = 3'b001;
        wait_grant("F_grant", 3'b001);
        bus.req_valid = 3'b000;
        step(1);
        check("F_wait", state, ST_WAIT);
        rst_n = 1'b0;
        deploy_req = 1'b0;
        bus.gov_approval_ack = 1'b1;
        step(1);
        check("F_state", state, ST_IDLE);
        check("F_start", bus.gov_check_start, 1'b0);
        check("F_busy", busy, 1'b0);
        check("F_rsp", bus.rsp_valid, 3'b000);
        check("F_sdone", session_done, 1'b0);
        check("F_id", bus.gov_signer_id, 8'h00);
        check("F_hash", bus.gov_hash, 128'h0);
        bus.gov_approval_ack = 1'b0;
        rst_n = 1'b1;
        step(2);
        check("F_no_rsp", bus.rsp_valid, 3'b000);
        check("F_no_sdone", session_done, 1'b0);
        check("F_idle", state, ST_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
